fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-side producer for the decode stage. Holds the PC and issues word fetches on the sram-like ibus (addr_ok/data_ok).
//  Buffers returned words and presents {raw_instr, pc, pcplus4, exc_adel} to the decoder with valid/ready.
//  Handles redirects from branch/jump/exception: flushes the buffer and discards in-flight responses.
// PARAMETERS
//  FIFO_DEPTH  4             entries in the fetch buffer; power of 2, >=2; also the max outstanding requests
//  RESET_PC    32'hbfc0_0000 PC loaded on reset
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  ireq_valid     out  1   ibus request valid
//  ireq_addr      out  32  ibus request address (word aligned)
//  iresp_addr_ok  in   1   request accepted this cycle
//  iresp_data_ok  in   1   response data valid this cycle, returned in request order
//  iresp_data     in   32  response instruction word
//  redirect_valid in   1   redirect this cycle (taken branch/jump/exception/eret)
//  redirect_pc    in   32  new fetch PC
//  out_valid      out  1   buffer head valid
//  out_ready      in   1   decoder consumes the head when out_valid & out_ready
//  out_raw_instr  out  32  instruction word; 0 when out_exc_adel
//  out_pc         out  32  PC of the head instruction
//  out_pcplus4    out  32  out_pc + 4, mod 2^32
//  out_exc_adel   out  1   head is a fetch address-error entry (pc[1:0]!=0)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, fifo empty, outstanding=0, discard=0. ireq_valid=0, out_valid=0, all out_* data outputs 0.
//  Request issue: ireq_valid=1 in RUN when pc[1:0]==0 and (fifo_count+outstanding)<FIFO_DEPTH; ireq_addr=pc.
//   Once ireq_valid=1 without addr_ok, ireq_valid and ireq_addr stay stable until addr_ok.
//  On addr_ok: pc+=4 (wrap mod 2^32) and outstanding++.
//  On data_ok: outstanding--. If discard>0, then discard-- and the word is dropped. Otherwise push {data, pc_of_req, adel=0}.
//   pc_of_req comes from an internal in-order tag queue of request PCs, depth FIFO_DEPTH.
//  Latency: addr_ok at cycle N, data_ok at cycle >=N+1. The pushed entry is visible on out_* at the cycle after data_ok (registered buffer).
//  Output: out_* reflect the fifo head. The head pops on out_valid&out_ready. Push and pop in the same cycle are allowed at full and at empty.
//  FSM states:
//   RUN: normal fetching.
//   STALE: a request was pending (ireq_valid=1, no addr_ok) when a redirect arrived. The old request stays presented until addr_ok.
//    At addr_ok its response is counted into discard. Then pc=saved redirect_pc and the FSM returns to RUN.
//   FAULT: reached from RUN when pc[1:0]!=0 and the fifo has space. Push one {0, pc, adel=1} entry. No ibus request is issued.
//    Stay in FAULT until a redirect arrives.
//  Redirect (any state): fifo flushed (same-cycle push and pop ignored). discard=outstanding-minus-this-cycle's-data_ok.
//   Any tag queue entries are dropped with their responses.
//   If no unaccepted request is pending, or addr_ok arrives the same cycle: pc=redirect_pc, state=RUN.
//   Otherwise: save redirect_pc, state=STALE.
//   A redirect while in STALE overwrites the saved PC.
//  Redirect beats fill and consume in the same cycle. out_valid=0 in the next cycle.
//  Counters are sized clog2(FIFO_DEPTH)+1; none can overflow by construction.
//  data_ok with outstanding==0 is illegal (SVA assertion, no RTL handling).
// STRUCTURE
//  Package fetch_pkg: fetch_entry_t {word_t pc; instr_t raw_instr; logic exc_adel;} and fetch_state_t {RUN, STALE, FAULT}.
//   Reuses word_t and instr_t from common.
//  Sub-module fetch_fifo #(DEPTH, type T): synchronous FIFO with push/pop/flush, full/empty/count. Used for the entry buffer and the tag queue.
// TESTING
//  1. Reset, addr_ok/data_ok tied 1, out_ready=1 -> addresses bfc00000, bfc00004, ... in order. Head PC bfc00000, pcplus4 bfc00004.
//  2. out_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then ireq_valid=0. One pop -> exactly one new request.
//  3. 3 requests outstanding, redirect to 0x80001000 -> 3 stale data_ok dropped, out_valid=0, first delivered out_pc=80001000.
//  4. addr_ok held 0 while ireq_addr=bfc00008, redirect to 0x80000000 -> addr stays bfc00008 until addr_ok. Its data is dropped, next addr=80000000.
//  5. Redirect to 0x80000002 -> no ibus request. One entry with exc_adel=1, raw_instr=0, pc=80000002. Idle until redirect to 0x80000004 resumes fetching.
//  6. Reset asserted with 2 outstanding -> outputs at reset values next cycle, pc=bfc00000. Bench flushes the ibus model; no spurious push.

Source files
------------

// File: rtl/common_pkg.sv
// Shared scalar types for the CPU datapath.
package common_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] instr_t;

endpackage

// File: rtl/fetch_pkg.sv
// Types shared by the fetch unit, its buffers and the bench.
package fetch_pkg;

    import common_pkg::*;

    typedef struct packed {
        word_t  pc;
        instr_t raw_instr;
        logic   exc_adel;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StRun,
        StStale,
        StFault
    } fetch_state_t;

    localparam word_t InstrStep = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// sram-like instruction bus: request with addr_ok, in-order responses with data_ok.
interface fetch_if;

    logic                ireq_valid;
    common_pkg::word_t   ireq_addr;
    logic                iresp_addr_ok;
    logic                iresp_data_ok;
    common_pkg::instr_t  iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output T                       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, ibus request issue, response buffering and redirect
// handling with discard of responses that belong to the abandoned path.
module fetch_unit
    import common_pkg::*;
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter word_t       RESET_PC   = 32'hbfc0_0000
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master ibus,
    input  logic   redirect_valid,
    input  word_t  redirect_pc,
    output logic   out_valid,
    input  logic   out_ready,
    output instr_t out_raw_instr,
    output word_t  out_pc,
    output word_t  out_pcplus4,
    output logic   out_exc_adel
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q;
    word_t           pc_q;
    word_t           saved_pc_q;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;

    logic [CntW-1:0] buf_count, tag_count;
    logic [CntW:0]   inflight;
    logic            has_room, req_valid, req_fire, keep_word, fault_push, tag_push;
    logic            buf_push, buf_pop, buf_empty, buf_full, tag_empty, tag_full;
    fetch_entry_t    buf_wdata, buf_head;
    word_t           tag_head;

    // Buffered entries plus in-flight responses must fit the buffer.
    assign inflight = {1'b0, buf_count} + {1'b0, outstanding_q};
    assign has_room = inflight < (CntW + 1)'(FIFO_DEPTH);

    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            StRun:   req_valid = (pc_q[1:0] == 2'b00) && has_room;
            StStale: req_valid = 1'b1;
            default: req_valid = 1'b0;
        endcase
    end

    assign ibus.ireq_valid = req_valid && !reset;
    assign ibus.ireq_addr  = pc_q;

    assign req_fire   = ibus.ireq_valid && ibus.iresp_addr_ok;
    assign keep_word  = ibus.iresp_data_ok && (discard_q == '0) && !redirect_valid;
    assign fault_push = (state_q == StRun) && (pc_q[1:0] != 2'b00) && has_room && tag_empty
                        && !redirect_valid;
    assign tag_push   = req_fire && (state_q == StRun) && !redirect_valid;
    assign buf_push   = keep_word || fault_push;
    assign buf_pop    = out_valid && out_ready;

    always_comb begin
        buf_wdata = '0;
        if (keep_word) begin
            buf_wdata.pc        = tag_head;
            buf_wdata.raw_instr = ibus.iresp_data;
        end else begin
            buf_wdata.pc       = pc_q;
            buf_wdata.exc_adel = 1'b1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(ibus.iresp_data_ok);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            discard_d = outstanding_d;
        end else begin
            discard_d = discard_q - CntW'(ibus.iresp_data_ok && (discard_q != '0))
                        + CntW'(req_fire && (state_q == StStale));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            saved_pc_q    <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect_valid) begin
                if (!ibus.ireq_valid || req_fire) begin
                    pc_q    <= redirect_pc;
                    state_q <= StRun;
                end else begin
                    saved_pc_q <= redirect_pc;
                    state_q    <= StStale;
                end
            end else begin
                case (state_q)
                    StRun: begin
                        if (req_fire) begin
                            pc_q <= pc_q + InstrStep;
                        end else if (fault_push) begin
                            state_q <= StFault;
                        end
                    end
                    StStale: begin
                        if (req_fire) begin
                            pc_q    <= saved_pc_q;
                            state_q <= StRun;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (buf_push),
        .push_data_i (buf_wdata),
        .pop_i       (buf_pop),
        .flush_i     (redirect_valid),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .T     (word_t)
    ) u_tag (
        .clk         (clk),
        .reset       (reset),
        .push_i      (tag_push),
        .push_data_i (pc_q),
        .pop_i       (keep_word),
        .flush_i     (redirect_valid),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    assign out_valid     = !buf_empty;
    assign out_pc        = out_valid ? buf_head.pc : '0;
    assign out_raw_instr = out_valid ? buf_head.raw_instr : '0;
    assign out_exc_adel  = out_valid && buf_head.exc_adel;
    assign out_pcplus4   = out_valid ? (buf_head.pc + InstrStep) : '0;

    a_data_needs_request: assert property (@(posedge clk) disable iff (reset)
        ibus.iresp_data_ok |-> (outstanding_q != '0));
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        buf_push |-> (!buf_full || buf_pop));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        tag_push |-> !tag_full);
    a_tag_bounded: assert property (@(posedge clk) disable iff (reset)
        tag_count <= outstanding_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ibus slave model, scoreboard of expected decode entries.
module tb_fetch_unit;

    import common_pkg::*;
    import fetch_pkg::*;

    localparam int unsigned Depth   = 4;
    localparam word_t       ResetPc = 32'hbfc0_0000;

    logic   clk = 1'b0;
    logic   reset;
    logic   redirect_valid;
    word_t  redirect_pc;
    logic   out_valid;
    logic   out_ready;
    instr_t out_raw_instr;
    word_t  out_pc;
    word_t  out_pcplus4;
    logic   out_exc_adel;

    fetch_if bus ();

    fetch_unit #(
        .FIFO_DEPTH (Depth),
        .RESET_PC   (ResetPc)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_raw_instr  (out_raw_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .out_exc_adel   (out_exc_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t  pc;
        word_t  pcplus4;
        instr_t raw;
        logic   adel;
    } exp_t;

    typedef struct {
        word_t target;
        logic  adel;
        word_t pcplus4;
    } vec_t;

    exp_t  exp_q[$];
    word_t pend_q[$];
    word_t acc_log[$];
    logic  addr_en, data_en, ready_en;
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic instr_t mem_word(word_t a);
        return a ^ 32'h5a5a_c3c3;
    endfunction

    task automatic chk(string name, word_t act, word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One cycle: drive the slave and consumer at negedge, score any pop that the next edge takes.
    task automatic tick();
        @(negedge clk);
        if (data_en && pend_q.size() > 0) begin
            bus.iresp_data_ok = 1'b1;
            bus.iresp_data    = mem_word(pend_q.pop_front());
        end else begin
            bus.iresp_data_ok = 1'b0;
            bus.iresp_data    = '0;
        end
        bus.iresp_addr_ok = addr_en;
        if (addr_en && bus.ireq_valid) begin
            pend_q.push_back(bus.ireq_addr);
            acc_log.push_back(bus.ireq_addr);
        end
        out_ready = ready_en && (exp_q.size() > 0);
        if (out_valid && out_ready && !redirect_valid) begin
            exp_t e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_pcplus4", out_pcplus4, e.pcplus4);
            chk("out_raw_instr", out_raw_instr, e.raw);
            chk("out_exc_adel", 32'(out_exc_adel), 32'(e.adel));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        out_ready         = 1'b0;
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;
        pend_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst ireq_valid", 32'(bus.ireq_valid), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_pcplus4", out_pcplus4, 32'd0);
        chk("rst out_raw_instr", out_raw_instr, 32'd0);
        chk("rst out_exc_adel", 32'(out_exc_adel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        acc_log.delete();
    endtask

    task automatic push_run(word_t start, int n);
        word_t p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: p, pcplus4: p + 32'd4, raw: mem_word(p), adel: 1'b0});
            p = p + 32'd4;
        end
    endtask

    task automatic wait_drain(string name, int budget);
        int i = 0;
        while (exp_q.size() > 0 && i < budget) begin
            tick();
            i++;
        end
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL %s: %0d entries still missing after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_redirect(word_t target);
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        @(posedge clk);
        #1;
        chk("out_valid after redirect", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
    endtask

    task automatic accept_n(int n);
        for (int i = 0; i < 40 && acc_log.size() < n; i++) begin
            tick();
        end
        addr_en = 1'b0;
        chk("accepted count", 32'(acc_log.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[6];
        int    n0;
        vecs[0] = '{target: 32'h8000_1000, adel: 1'b0, pcplus4: 32'h8000_1004};
        vecs[1] = '{target: 32'h8000_0002, adel: 1'b1, pcplus4: 32'h8000_0006};
        vecs[2] = '{target: 32'h8000_0004, adel: 1'b0, pcplus4: 32'h8000_0008};
        vecs[3] = '{target: 32'hffff_fffc, adel: 1'b0, pcplus4: 32'h0000_0000};
        vecs[4] = '{target: 32'h0000_0001, adel: 1'b1, pcplus4: 32'h0000_0005};
        vecs[5] = '{target: 32'h1234_5678, adel: 1'b0, pcplus4: 32'h1234_567c};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        addr_en        = 1'b0;
        data_en        = 1'b0;
        ready_en       = 1'b0;
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;

        // Straight-line fetch with a always-ready bus and decoder.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b1; ready_en = 1'b1;
        push_run(ResetPc, 8);
        wait_drain("t1 drain", 100);
        for (int i = 0; i < 4; i++) begin
            chk("t1 ireq_addr", acc_log[i], ResetPc + 32'(4 * i));
        end

        // Decoder stalled: buffer plus outstanding capped at Depth.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b1; ready_en = 1'b1;
        repeat (20) tick();
        chk("t2 requests at full", 32'(acc_log.size()), 32'(Depth));
        chk("t2 ireq_valid at full", 32'(bus.ireq_valid), 32'd0);
        chk("t2 out_valid at full", 32'(out_valid), 32'd1);
        push_run(ResetPc, 1);
        wait_drain("t2 single pop", 20);
        repeat (10) tick();
        chk("t2 requests after pop", 32'(acc_log.size()), 32'(Depth + 1));
        chk("t2 refill addr", acc_log[Depth], ResetPc + 32'(4 * Depth));

        // Redirect with three responses still in flight.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b0; ready_en = 1'b1;
        accept_n(3);
        addr_en = 1'b1; data_en = 1'b1;
        do_redirect(32'h8000_1000);
        push_run(32'h8000_1000, 3);
        wait_drain("t3 drain", 60);

        // Redirect while a request is presented but not accepted.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b1; ready_en = 1'b1;
        accept_n(2);
        repeat (3) tick();
        chk("t4 pending valid", 32'(bus.ireq_valid), 32'd1);
        chk("t4 pending addr", bus.ireq_addr, 32'hbfc0_0008);
        do_redirect(32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4 stale valid", 32'(bus.ireq_valid), 32'd1);
            chk("t4 stale addr", bus.ireq_addr, 32'hbfc0_0008);
        end
        addr_en = 1'b1;
        push_run(32'h8000_0000, 2);
        wait_drain("t4 drain", 60);
        chk("t4 stale accepted", acc_log[2], 32'hbfc0_0008);
        chk("t4 next addr", acc_log[3], 32'h8000_0000);

        // Table of redirect targets: aligned, misaligned (fault entry), wrap-around.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b1; ready_en = 1'b1;
        foreach (vecs[k]) begin
            do_redirect(vecs[k].target);
            n0 = acc_log.size();
            exp_q.push_back('{pc: vecs[k].target, pcplus4: vecs[k].pcplus4,
                              raw: vecs[k].adel ? 32'd0 : mem_word(vecs[k].target),
                              adel: vecs[k].adel});
            if (!vecs[k].adel) begin
                push_run(vecs[k].target + 32'd4, 1);
            end
            wait_drain("vec drain", 60);
            if (vecs[k].adel) begin
                repeat (8) tick();
                chk("fault no request", 32'(acc_log.size()), 32'(n0));
                chk("fault ireq_valid", 32'(bus.ireq_valid), 32'd0);
                chk("fault single entry", 32'(out_valid), 32'd0);
            end
        end

        // Reset with two responses outstanding.
        apply_reset();
        addr_en = 1'b1; data_en = 1'b0; ready_en = 1'b1;
        accept_n(2);
        apply_reset();
        addr_en = 1'b1; data_en = 1'b1; ready_en = 1'b1;
        push_run(ResetPc, 2);
        wait_drain("t6 drain", 40);
        chk("t6 first addr", acc_log[0], ResetPc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
